muldiv_ctrl: RTL and testbench

//  Sequencer for the HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO (+ MADD family) from EX,

---
 rtl/muldiv_ctrl_pkg.sv | 36 +++
 rtl/muldiv_ctrl_if.sv | 31 +++
 rtl/muldiv_ctrl_div_iter.sv | 51 +++++
 rtl/muldiv_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Holds the op and state encodings plus small operand helpers.
package muldiv_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MTHI,
    MD_MTLO,
    MD_MADD,
    MD_MADDU,
    MD_MSUB,
    MD_MSUBU
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_WB
  } muldiv_state_t;

  localparam int DIV_ITERS = 32;

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

  function automatic logic is_signed_op(input muldiv_op_t op);
    return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request, flush and HI/LO write-port bundle between EX, the sequencer
// and the HI/LO register block.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic       req_valid;
  logic       req_ready;
  muldiv_op_t req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic       flush;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic       busy;
  logic       hi_write;
  logic       lo_write;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic       done;

  modport master (
    output req_valid, req_op, req_a, req_b, flush, hi_in, lo_in,
    input  req_ready, busy, hi_write, lo_write, hi_data, lo_data, done
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, hi_in, lo_in,
    output req_ready, busy, hi_write, lo_write, hi_data, lo_data, done
  );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle,
// results valid DIV_ITERS cycles after start.
module div_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);

  logic [31:0] dsr;
  logic [5:0]  left;
  logic [32:0] trial;
  logic [32:0] diff;

  // The quotient register doubles as the dividend shift register.
  assign trial = {remainder, quotient[31]};
  assign diff  = trial - {1'b0, dsr};

  always_ff @(posedge clk) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      dsr       <= '0;
      left      <= '0;
      valid     <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      dsr       <= divisor;
      left      <= 6'(DIV_ITERS);
      valid     <= 1'b0;
    end else if (left != 6'd0) begin
      if (!diff[32]) begin
        remainder <= diff[31:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= trial[31:0];
        quotient  <= {quotient[30:0], 1'b0};
      end
      left  <= left - 6'd1;
      valid <= (left == 6'd1);
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: multiply pipeline, iterative divide with sign fix-up, one write cycle.
// Optional MULDIV_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate path.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  muldiv_ctrl_if.slave bus
);

  muldiv_state_t state;
  muldiv_op_t    op_q;
  logic [31:0]   a_q, b_q, hi_q, lo_q;
  logic [4:0]    cnt;
  logic          q_neg, r_neg, busy_q, hi_wr_q, lo_wr_q, done_q, madd_q, msub_q;
  logic          accept, req_signed, div_start, div_valid, mul_signed;
  logic [31:0]   dividend_mag, divisor_mag, quotient, remainder;
  logic [65:0]   mul_a, mul_b, prod_full;
  logic [63:0]   prod, prod_out;

  assign accept       = bus.req_valid && bus.req_ready;
  assign req_signed   = is_signed_op(bus.req_op);
  assign div_start    = accept && (bus.req_op inside {MD_DIV, MD_DIVU}) && (bus.req_b != 32'd0);
  assign dividend_mag = magnitude(bus.req_a, req_signed);
  assign divisor_mag  = magnitude(bus.req_b, req_signed);

  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (dividend_mag),
    .divisor   (divisor_mag),
    .quotient  (quotient),
    .remainder (remainder),
    .valid     (div_valid)
  );

  // 33-bit extension then mod-2^66 product; the low 64 bits are exact for both signednesses.
  assign mul_signed = is_signed_op(op_q);
  assign mul_a      = {{34{mul_signed & a_q[31]}}, a_q};
  assign mul_b      = {{34{mul_signed & b_q[31]}}, b_q};
  assign prod_full  = mul_a * mul_b;
  assign prod       = prod_full[63:0];

  if (MUL_LAT <= 1) begin : g_mul_comb
    assign prod_out = prod;
  end else begin : g_mul_pipe
    logic [63:0] pipe [MUL_LAT-1];
    always_ff @(posedge clk) begin
      pipe[0] <= prod;
      for (int i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign prod_out = pipe[MUL_LAT-2];
  end

  assign bus.req_ready = (state == ST_IDLE) && !bus.flush;
  assign bus.busy      = busy_q;
  assign bus.hi_write  = hi_wr_q && !bus.flush;
  assign bus.lo_write  = lo_wr_q && !bus.flush;
  assign bus.done      = done_q && !bus.flush;

`ifdef MULDIV_MADD_EN
  logic [63:0] acc;
  // The accumulate source is whatever HI/LO hold during the write cycle itself.
  assign acc = msub_q ? ({bus.hi_in, bus.lo_in} - {hi_q, lo_q})
                      : ({bus.hi_in, bus.lo_in} + {hi_q, lo_q});
  assign bus.hi_data = madd_q ? acc[63:32] : hi_q;
  assign bus.lo_data = madd_q ? acc[31:0]  : lo_q;
  logic unused_bits;
  assign unused_bits = ^prod_full[65:64];
`else
  assign bus.hi_data = hi_q;
  assign bus.lo_data = lo_q;
  logic unused_bits;
  assign unused_bits = ^{bus.hi_in, bus.lo_in, madd_q, msub_q, prod_full[65:64]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      busy_q  <= 1'b0;
      hi_wr_q <= 1'b0;
      lo_wr_q <= 1'b0;
      done_q  <= 1'b0;
      madd_q  <= 1'b0;
      msub_q  <= 1'b0;
    end else if (state != ST_IDLE && bus.flush) begin
      state   <= ST_IDLE;
      busy_q  <= 1'b0;
      hi_wr_q <= 1'b0;
      lo_wr_q <= 1'b0;
      done_q  <= 1'b0;
      madd_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op_q   <= bus.req_op;
          a_q    <= bus.req_a;
          b_q    <= bus.req_b;
          busy_q <= 1'b1;
          q_neg  <= req_signed && (bus.req_a[31] ^ bus.req_b[31]);
          r_neg  <= req_signed && bus.req_a[31];
          case (bus.req_op)
            MD_MULT, MD_MULTU: begin
              state <= ST_MUL;
              cnt   <= 5'(MUL_LAT - 1);
            end
            MD_DIV, MD_DIVU: begin
              if (bus.req_b == 32'd0) begin
                state   <= ST_WB;
                hi_q    <= bus.req_a;
                lo_q    <= 32'hFFFF_FFFF;
                hi_wr_q <= 1'b1;
                lo_wr_q <= 1'b1;
                done_q  <= 1'b1;
              end else begin
                state <= ST_DIV;
                cnt   <= 5'(DIV_ITERS - 1);
              end
            end
            MD_MTHI: begin
              state   <= ST_WB;
              hi_q    <= bus.req_a;
              hi_wr_q <= 1'b1;
              done_q  <= 1'b1;
            end
            MD_MTLO: begin
              state   <= ST_WB;
              lo_q    <= bus.req_a;
              lo_wr_q <= 1'b1;
              done_q  <= 1'b1;
            end
`ifdef MULDIV_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
              state  <= ST_MUL;
              cnt    <= 5'(MUL_LAT - 1);
              madd_q <= 1'b1;
              msub_q <= bus.req_op inside {MD_MSUB, MD_MSUBU};
            end
`endif
            default: begin
              state  <= ST_WB;
              done_q <= 1'b1;
            end
          endcase
        end
        ST_MUL: begin
          if (cnt == 5'd0) begin
            state        <= ST_WB;
            {hi_q, lo_q} <= prod_out;
            hi_wr_q      <= 1'b1;
            lo_wr_q      <= 1'b1;
            done_q       <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_DIV: begin
          if (cnt == 5'd0) state <= ST_FIX;
          else             cnt   <= cnt - 5'd1;
        end
        ST_FIX: if (div_valid) begin
          state   <= ST_WB;
          lo_q    <= q_neg ? (~quotient + 32'd1)  : quotient;
          hi_q    <= r_neg ? (~remainder + 32'd1) : remainder;
          hi_wr_q <= 1'b1;
          lo_wr_q <= 1'b1;
          done_q  <= 1'b1;
        end
        ST_WB: begin
          state   <= ST_IDLE;
          busy_q  <= 1'b0;
          hi_wr_q <= 1'b0;
          lo_wr_q <= 1'b0;
          done_q  <= 1'b0;
          madd_q  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases with literal results,
// then randomized traffic against an arithmetic reference model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one outstanding op, its write cycle and the values it must write.
  logic        m_active = 1'b0;
  int          m_acc, m_wb;
  logic        m_we_hi, m_we_lo, m_madd, m_sub;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_prod;
  logic        in_op, wr_ok;
  logic [63:0] exp_acc;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] product(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic modelAccept(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    m_active = 1'b1;
    m_acc    = cyc;
    m_we_hi  = 1'b0;
    m_we_lo  = 1'b0;
    m_madd   = 1'b0;
    m_sub    = 1'b0;
    m_hi     = '0;
    m_lo     = '0;
    m_wb     = cyc + 1;
    case (op)
      MD_MULT, MD_MULTU: begin
        {m_hi, m_lo} = product(op == MD_MULT, a, b);
        m_we_hi = 1'b1;
        m_we_lo = 1'b1;
        m_wb    = cyc + MUL_LAT + 1;
      end
      MD_DIV, MD_DIVU: begin
        m_we_hi = 1'b1;
        m_we_lo = 1'b1;
        if (b == 32'd0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          m_wb = cyc + 34;
          if (op == MD_DIVU) begin
            m_lo = a / b;
            m_hi = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'd0;
          end else begin
            m_lo = 32'($signed(a) / $signed(b));
            m_hi = 32'($signed(a) % $signed(b));
          end
        end
      end
      MD_MTHI: begin
        m_hi    = a;
        m_we_hi = 1'b1;
      end
      MD_MTLO: begin
        m_lo    = a;
        m_we_lo = 1'b1;
      end
      default: begin
`ifdef MULDIV_MADD_EN
        m_madd  = 1'b1;
        m_sub   = op inside {MD_MSUB, MD_MSUBU};
        m_prod  = product(op inside {MD_MADD, MD_MSUB}, a, b);
        m_we_hi = 1'b1;
        m_we_lo = 1'b1;
        m_wb    = cyc + MUL_LAT + 1;
`endif
      end
    endcase
  endtask

  // Every cycle out of reset the DUT outputs are compared with the model.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      m_active = 1'b0;
    end else begin
      in_op = m_active && (cyc > m_acc) && (cyc <= m_wb);
      wr_ok = in_op && (cyc == m_wb) && !bus.flush;
      checkOutput("busy", 64'(bus.busy), 64'(in_op));
      checkOutput("req_ready", 64'(bus.req_ready), 64'(!in_op && !bus.flush));
      checkOutput("done", 64'(bus.done), 64'(wr_ok));
      checkOutput("hi_write", 64'(bus.hi_write), 64'(wr_ok && m_we_hi));
      checkOutput("lo_write", 64'(bus.lo_write), 64'(wr_ok && m_we_lo));
      if (wr_ok && m_madd) begin
        exp_acc = m_sub ? ({bus.hi_in, bus.lo_in} - m_prod) : ({bus.hi_in, bus.lo_in} + m_prod);
        checkOutput("madd_data", {bus.hi_data, bus.lo_data}, exp_acc);
      end else begin
        if (wr_ok && m_we_hi) checkOutput("hi_data", 64'(bus.hi_data), 64'(m_hi));
        if (wr_ok && m_we_lo) checkOutput("lo_data", 64'(bus.lo_data), 64'(m_lo));
      end
      if (in_op && (bus.flush || cyc == m_wb)) m_active = 1'b0;
      if (!in_op && !bus.flush && bus.req_valid) modelAccept(bus.req_op, bus.req_a, bus.req_b);
    end
  end

  task automatic issueOnly(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask

  // Returns the write cycle relative to the accept cycle, 0 if done never came.
  task automatic applyStimulus(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                               output int lat);
    issueOnly(op, a, b);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int lat;
  int seen;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = MD_MULT;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.flush     = 1'b0;
    bus.hi_in     = 32'd0;
    bus.lo_in     = 32'hFFFF_FFFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_writes", 64'({bus.hi_write, bus.lo_write}), 64'd0);
    checkOutput("rst_data", {bus.hi_data, bus.lo_data}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'd3, lat);
    checkOutput("mult_lat", 64'(lat), 64'(MUL_LAT + 1));
    checkOutput("mult_res", {bus.hi_data, bus.lo_data}, 64'hFFFF_FFFF_FFFF_FFFA);
    applyStimulus(MD_MULTU, 32'hFFFF_FFFE, 32'd3, lat);
    checkOutput("multu_res", {bus.hi_data, bus.lo_data}, 64'h0000_0002_FFFF_FFFA);

    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    checkOutput("div_lat", 64'(lat), 64'd34);
    checkOutput("div_res", {bus.hi_data, bus.lo_data}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(MD_DIVU, 32'd100, 32'd7, lat);
    checkOutput("divu_res", {bus.hi_data, bus.lo_data}, {32'd2, 32'd14});
    applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checkOutput("div_ovf_res", {bus.hi_data, bus.lo_data}, 64'h0000_0000_8000_0000);

    applyStimulus(MD_DIVU, 32'd5, 32'd0, lat);
    checkOutput("divz_lat", 64'(lat), 64'd1);
    checkOutput("divz_res", {bus.hi_data, bus.lo_data}, {32'd5, 32'hFFFF_FFFF});
    @(negedge clk);
    checkOutput("divz_busy_after", 64'(bus.busy), 64'd0);

    applyStimulus(MD_MTLO, 32'h1234, 32'd0, lat);
    checkOutput("mtlo_lat", 64'(lat), 64'd1);
    checkOutput("mtlo_strobes", 64'({bus.hi_write, bus.lo_write}), 64'b01);
    checkOutput("mtlo_data", 64'(bus.lo_data), 64'h1234);

    issueOnly(MD_DIV, 32'd100, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle", 64'(bus.busy), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.hi_write || bus.lo_write || bus.done) seen++;
    end
    checkOutput("flush_no_write", 64'(seen), 64'd0);
    applyStimulus(MD_MULT, 32'd7, 32'd6, lat);
    checkOutput("post_flush_mult", {bus.hi_data, bus.lo_data, 32'(lat)} >> 32, {32'd0, 32'd42});

    issueOnly(MD_MTHI, 32'hABCD, 32'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("wb_flush_strobes", 64'({bus.hi_write, bus.lo_write, bus.done}), 64'd0);
    bus.req_valid = 1'b1;
    bus.req_op    = MD_MTLO;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle_no_accept", 64'(bus.busy), 64'd0);

    issueOnly(MD_DIVU, 32'd1000, 32'd9);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.hi_write || bus.lo_write) seen++;
    end
    checkOutput("reset_abandons", 64'(seen), 64'd0);

    bus.hi_in = 32'd0;
    bus.lo_in = 32'hFFFF_FFFF;
    applyStimulus(MD_MADDU, 32'd1, 32'd1, lat);
`ifdef MULDIV_MADD_EN
    checkOutput("maddu_lat", 64'(lat), 64'(MUL_LAT + 1));
    checkOutput("maddu_res", {bus.hi_data, bus.lo_data}, 64'h0000_0001_0000_0000);
`else
    checkOutput("maddu_lat", 64'(lat), 64'd1);
    checkOutput("maddu_no_write", 64'({bus.hi_write, bus.lo_write}), 64'd0);
`endif

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      bus.req_valid = ($urandom_range(0, 2) == 0);
      bus.req_op    = muldiv_op_t'($urandom_range(0, 9));
      bus.req_a     = pickOperand();
      bus.req_b     = pickOperand();
      bus.flush     = ($urandom_range(0, 49) == 0);
      bus.hi_in     = $urandom;
      bus.lo_in     = $urandom;
      reset         = ($urandom_range(0, 999) == 0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    reset         = 1'b0;
    repeat (50) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
